shift_buffer_sequencer: RTL and testbench
=========================================

// Module: shift_buffer_sequencer
// PURPOSE
//  Sequences one 4x4 activation tile through the skewed shift buffer into the systolic array.
//  - Accepts a 16-element tile over a valid/ready handshake and holds it stable.
//  - Issues a single-cycle parallel load to the shift buffer.
//  - Gates the array for the stream and drain windows, then reports the result as valid.
//  - Sits between the tile fetch logic and the ShiftBuffer + PE array.
// PARAMETERS
//  WIDTH         8  activation element width in bits
//  DRAIN_CYCLES  4  cycles the array runs after the last skewed element leaves the buffer (>=1)
// PORTS
//  clk            in   1          clock, rising edge
//  reset          in   1          asynchronous, active-low reset
//  in_valid       in   1          upstream tile valid
//  in_ready       out  1          sequencer can accept a tile
//  in_activation  in   16*WIDTH   tile; element e at [e*WIDTH +: WIDTH]
//  abort          in   1          synchronous cancel of the current tile
//  sb_load        out  1          to ShiftBuffer load
//  sb_activation  out  16*WIDTH   to ShiftBuffer activation; the captured tile
//  acc_clear      out  1          clears the PE accumulators (one-cycle pulse)
//  array_en       out  1          PE array compute enable
//  out_valid      out  1          array results are complete and stable
//  out_ready      in   1          downstream has consumed the results
// BEHAVIOUR
//  Reset values (reset low)
//   - State is IDLE; all outputs are 0, including sb_activation; the counter is 0.
//   - Reset may assert in any state: the sequencer returns to IDLE and any tile in flight is dropped.
//  States (Moore; every output is decoded from registered state): IDLE -> LOAD -> STREAM -> DRAIN -> DONE -> IDLE
//  IDLE
//   - in_ready = !abort.
//   - On in_valid && in_ready: capture in_activation into sb_activation, then go to LOAD.
//  LOAD (1 cycle)
//   - sb_load = 1 and acc_clear = 1; all other outputs are 0.
//   - Counter is cleared; next state is STREAM.
//  STREAM (STREAM_CYCLES = 7)
//   - array_en = 1; sb_load = 0, so the buffer shifts.
//   - Covers 4 data cycles plus 3 cycles of skew padding on row 4.
//  DRAIN (DRAIN_CYCLES)
//   - array_en = 1; the buffer keeps shifting zeros.
//  DONE
//   - out_valid = 1 and array_en = 0; out_valid is held until out_ready.
//   - On out_ready: go to IDLE. The next tile can be accepted no earlier than the following cycle.
//  Counter: width $clog2(max(STREAM_CYCLES, DRAIN_CYCLES)+1); it counts 0..N-1 and is cleared on every state change.
//  sb_activation changes only on an accepted handshake; it is stable for the whole tile.
//  abort
//   - Asserted in any non-IDLE state: next cycle is IDLE, and sb_load, array_en and out_valid deassert.
//   - sb_activation holds its value.
//  Simultaneous events
//   - abort with in_valid in IDLE: no accept.
//   - abort with out_ready in DONE: IDLE, with no distinction between the two.
//  in_valid is ignored outside IDLE; in_activation is sampled only at the accept edge.
// CONFIGURATION
//  SEQ_PERF_CNT_EN defined
//   - Adds ports perf_tiles (out, 32) and perf_busy (out, 32); both reset to 0.
//   - perf_tiles increments on each DONE&&out_ready (not on abort).
//   - perf_busy increments on each cycle where state != IDLE.
//   - Both counters wrap modulo 2^32.
//  SEQ_PERF_CNT_EN undefined
//   - The ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  Package nnoc_seq_pkg
//   - seq_state_t enum {IDLE, LOAD, STREAM, DRAIN, DONE}.
//   - localparams TILE_DIM=4, TILE_ELEMS=16, STREAM_CYCLES=2*TILE_DIM-1.
//  Sub-module seq_phase_counter
//   - Loadable down-counter that raises a terminal-count flag; used for the STREAM and DRAIN windows.
//  The FSM and the capture register stay in this module.
// TESTING
//  1. Reset mid-STREAM: drop reset low for 1 cycle -> outputs 0 immediately, state IDLE, in_ready=1 after release.
//  2. Single tile, elements 0x01..0x10, accepted at cycle 0:
//     - sb_load=1 at cycle 1 only; acc_clear=1 at cycle 1.
//     - array_en=1 for cycles 2..12.
//     - out_valid rises at cycle 13; out_ready at cycle 15 -> in_ready=1 at cycle 16.
//  3. Back-to-back tiles with in_valid held high:
//     - Second accept occurs only in IDLE; sb_activation switches exactly at that edge.
//     - No sb_load overlaps array_en of the first tile.
//  4. abort at cycle 5 of STREAM -> IDLE next cycle; array_en=0; no out_valid; perf_tiles unchanged.
//  5. abort && in_valid in IDLE -> in_ready=0; no capture; sb_activation retains the old tile.
//  6. SEQ_PERF_CNT_EN, 3 tiles with out_ready tied to 1 (DRAIN_CYCLES=4) -> perf_tiles=3, perf_busy=3*13=39.

Source files
------------

// File: rtl/nnoc_seq_pkg.sv
// nnoc_seq_pkg: shared tile geometry and sequencer state encoding.
package nnoc_seq_pkg;
    localparam int TILE_DIM      = 4;
    localparam int TILE_ELEMS    = TILE_DIM * TILE_DIM;
    localparam int STREAM_CYCLES = 2 * TILE_DIM - 1;
    typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, DONE} seq_state_t;
endpackage

// File: rtl/shift_buffer_sequencer_if.sv
// shift_buffer_sequencer_if: tile handshake, shift-buffer and array control bundle.
interface shift_buffer_sequencer_if #(parameter int WIDTH = 8);
    import nnoc_seq_pkg::*;
    logic                          in_valid, in_ready, abort, out_ready;
    logic                          sb_load, acc_clear, array_en, out_valid;
    logic [TILE_ELEMS*WIDTH-1:0]   in_activation, sb_activation;
    modport master (output in_valid, in_activation, abort, out_ready,
                    input  in_ready, sb_load, sb_activation, acc_clear, array_en, out_valid);
    modport slave  (input  in_valid, in_activation, abort, out_ready,
                    output in_ready, sb_load, sb_activation, acc_clear, array_en, out_valid);
endinterface

// File: rtl/seq_phase_counter.sv
// seq_phase_counter: loadable down-counter flagging terminal count at zero.
module seq_phase_counter #(parameter int CW = 3) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          en,
    input  logic [CW-1:0] load_val,
    output logic          tc
);
    logic [CW-1:0] count;
    always_ff @(posedge clk or negedge reset)
        if (!reset) count <= '0;
        else if (load) count <= load_val;
        else if (en && !tc) count <= count - 1'b1;
    assign tc = count == '0;
endmodule

// File: rtl/shift_buffer_sequencer.sv
// shift_buffer_sequencer: sequences one 4x4 tile through the skewed shift buffer into the PE array.
// Optional SEQ_PERF_CNT_EN adds perf_tiles / perf_busy counters.
module shift_buffer_sequencer
    import nnoc_seq_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    shift_buffer_sequencer_if.slave bus
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0] perf_tiles,
    output logic [31:0] perf_busy
`endif
);
    localparam int TW = TILE_ELEMS * WIDTH;
    localparam int CW = $clog2((STREAM_CYCLES > DRAIN_CYCLES ? STREAM_CYCLES : DRAIN_CYCLES) + 1);
    seq_state_t    state, next;
    logic          accept, tc, cnt_load;
    logic [CW-1:0] cnt_val;
    logic [TW-1:0] tile_q;
    assign accept = bus.in_valid && bus.in_ready;
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= next;
    always_comb begin
        next = state;
        unique case (state)
            IDLE:    next = accept ? LOAD : IDLE;
            LOAD:    next = STREAM;
            STREAM:  next = tc ? DRAIN : STREAM;
            DRAIN:   next = tc ? DONE : DRAIN;
            DONE:    next = bus.out_ready ? IDLE : DONE;
            default: next = IDLE;
        endcase
        if (bus.abort) next = IDLE;
    end
    // in_ready is gated by reset so every output reads 0 while reset is held
    always_comb begin
        bus.in_ready  = reset && state == IDLE && !bus.abort;
        bus.sb_load   = state == LOAD;
        bus.acc_clear = state == LOAD;
        bus.array_en  = state == STREAM || state == DRAIN;
        bus.out_valid = state == DONE;
    end
    // window counter is reloaded on entry to STREAM and DRAIN
    assign cnt_load = state == LOAD || (state == STREAM && tc);
    assign cnt_val  = state == LOAD ? CW'(STREAM_CYCLES - 1) : CW'(DRAIN_CYCLES - 1);
    seq_phase_counter #(.CW(CW)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .en       (state == STREAM || state == DRAIN),
        .load_val (cnt_val),
        .tc       (tc)
    );
    always_ff @(posedge clk or negedge reset)
        if (!reset) tile_q <= '0;
        else if (accept) tile_q <= bus.in_activation;
    assign bus.sb_activation = tile_q;
`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            perf_tiles <= '0;
            perf_busy  <= '0;
        end else begin
            perf_tiles <= perf_tiles + 32'(state == DONE && bus.out_ready && !bus.abort);
            perf_busy  <= perf_busy + 32'(state != IDLE);
        end
`endif
endmodule

// File: tb/tb_shift_buffer_sequencer.sv
// tb_shift_buffer_sequencer: randomized bench against a cycles-since-accept reference model.
module tb_shift_buffer_sequencer;
    import nnoc_seq_pkg::*;
    localparam int W = 8;
    localparam int D = 4;
    localparam int DONE_AGE = 2 + STREAM_CYCLES + D;
    localparam int TB = TILE_ELEMS * W;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;
    shift_buffer_sequencer_if #(.WIDTH(W)) bus();
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_tiles, perf_busy;
`endif
    shift_buffer_sequencer #(.WIDTH(W), .DRAIN_CYCLES(D)) dut (
        .clk   (clk),
        .reset (reset_n),
        .bus   (bus)
`ifdef SEQ_PERF_CNT_EN
        ,
        .perf_tiles (perf_tiles),
        .perf_busy  (perf_busy)
`endif
    );
    int vectors = 0;
    int errors  = 0;
    bit m_busy;
    int m_age;
    logic [TB-1:0] m_tile;
    logic [31:0] m_tiles, m_cycles;
    logic [4:0] obs;
    assign obs = {bus.in_ready, bus.sb_load, bus.acc_clear, bus.array_en, bus.out_valid};

    function automatic logic [TB-1:0] rand_tile();
        logic [TB-1:0] t;
        for (int i = 0; i < TB / 32; i++) t[i*32 +: 32] = $urandom;
        return t;
    endfunction

    // expected {in_ready, sb_load, acc_clear, array_en, out_valid} from cycles since accept
    function automatic logic [4:0] exp_ctl();
        return {reset_n && !m_busy && !bus.abort, m_busy && m_age == 1, m_busy && m_age == 1,
                m_busy && m_age >= 2 && m_age < DONE_AGE, m_busy && m_age >= DONE_AGE};
    endfunction

    task automatic model_reset();
        m_busy = 0; m_age = 0; m_tile = '0; m_tiles = 0; m_cycles = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset_n) model_reset();
        else begin
            if (m_busy) m_cycles++;
            if (!m_busy) begin
                if (bus.in_valid && !bus.abort) begin
                    m_busy = 1; m_age = 1; m_tile = bus.in_activation;
                end
            end else if (bus.abort) m_busy = 0;
            else if (m_age >= DONE_AGE && bus.out_ready) begin
                m_busy = 0; m_tiles++;
            end else m_age++;
        end
        #1;
    endtask

    task automatic drain();
        bus.in_valid = 0; bus.abort = 0; bus.out_ready = 1;
        for (int i = 0; i < 40 && m_busy; i++) tick();
        bus.out_ready = 0;
    endtask

    task automatic test_reset();
        reset_n = 0; bus.in_valid = 0; bus.abort = 0; bus.out_ready = 0; bus.in_activation = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (obs !== 5'b0) begin errors++; $display("FAIL reset_ctl got=%b want=%b", obs, 5'b0); end
        vectors++;
        if (bus.sb_activation !== '0) begin errors++; $display("FAIL reset_sb got=%h want=0", bus.sb_activation); end
        reset_n = 1;
        #1;
        vectors++;
        if (obs !== 5'b10000) begin errors++; $display("FAIL reset_release got=%b want=%b", obs, 5'b10000); end
        bus.in_valid = 1; bus.in_activation = rand_tile();
        tick();
        bus.in_valid = 0;
        repeat (5) tick();
        vectors++;
        if (obs !== exp_ctl() || !bus.array_en) begin errors++; $display("FAIL reset_prestream got=%b want=%b", obs, exp_ctl()); end
        #2 reset_n = 0;
        model_reset();
        #1;
        vectors++;
        if (obs !== 5'b0) begin errors++; $display("FAIL reset_mid_ctl got=%b want=%b", obs, 5'b0); end
        vectors++;
        if (bus.sb_activation !== '0) begin errors++; $display("FAIL reset_mid_sb got=%h want=0", bus.sb_activation); end
        tick();
        reset_n = 1;
        #1;
        vectors++;
        if (obs !== 5'b10000) begin errors++; $display("FAIL reset_mid_release got=%b want=%b", obs, 5'b10000); end
    endtask

    task automatic test_single();
        logic [4:0] want;
        drain();
        for (int e = 0; e < TILE_ELEMS; e++) bus.in_activation[e*W +: W] = W'(e + 1);
        bus.in_valid = 1;
        #1;
        vectors++;
        if (!bus.in_ready) begin errors++; $display("FAIL single_ready got=%b want=1", bus.in_ready); end
        tick();
        bus.in_valid = 0; bus.in_activation = rand_tile();
        for (int c = 1; c <= 16; c++) begin
            bus.out_ready = (c == 15);
            #1;
            want = {c == 16, c == 1, c == 1, c >= 2 && c <= 12, c >= 13 && c <= 15};
            vectors++;
            if (obs !== want) begin errors++; $display("FAIL single_c%0d got=%b want=%b", c, obs, want); end
            vectors++;
            if (bus.sb_activation !== m_tile || bus.sb_activation[15*W +: W] !== 8'h10)
                begin errors++; $display("FAIL single_sb_c%0d got=%h want=%h", c, bus.sb_activation, m_tile); end
            tick();
        end
        bus.out_ready = 0;
    endtask

    task automatic test_back_to_back();
        drain();
        bus.in_valid = 1;
        for (int c = 0; c < 80; c++) begin
            bus.in_activation = rand_tile();
            bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            vectors++;
            if (obs !== exp_ctl() || (bus.sb_load && bus.array_en))
                begin errors++; $display("FAIL b2b_ctl_c%0d got=%b want=%b", c, obs, exp_ctl()); end
            vectors++;
            if (bus.sb_activation !== m_tile) begin errors++; $display("FAIL b2b_sb_c%0d got=%h want=%h", c, bus.sb_activation, m_tile); end
            tick();
        end
        bus.in_valid = 0;
    endtask

    task automatic test_abort();
`ifdef SEQ_PERF_CNT_EN
        logic [31:0] t0;
`endif
        drain();
`ifdef SEQ_PERF_CNT_EN
        t0 = perf_tiles;
`endif
        bus.in_valid = 1; bus.in_activation = rand_tile();
        tick();
        bus.in_valid = 0;
        for (int c = 1; c <= 20; c++) begin
            bus.abort = (c == 7);
            bus.out_ready = 1;
            #1;
            vectors++;
            if (obs !== exp_ctl() || (c == 8 && obs !== 5'b10000) || bus.out_valid)
                begin errors++; $display("FAIL abort_c%0d got=%b want=%b", c, obs, exp_ctl()); end
            tick();
        end
        bus.abort = 0;
        vectors++;
        if (bus.sb_activation !== m_tile) begin errors++; $display("FAIL abort_sb got=%h want=%h", bus.sb_activation, m_tile); end
`ifdef SEQ_PERF_CNT_EN
        vectors++;
        if (perf_tiles !== t0) begin errors++; $display("FAIL abort_perf got=%0d want=%0d", perf_tiles, t0); end
`endif
    endtask

    task automatic test_abort_idle();
        logic [TB-1:0] old;
        drain();
        old = bus.sb_activation;
        bus.in_valid = 1; bus.abort = 1; bus.in_activation = ~old;
        #1;
        vectors++;
        if (obs !== 5'b00000) begin errors++; $display("FAIL abort_idle_ready got=%b want=%b", obs, 5'b0); end
        tick();
        bus.in_valid = 0; bus.abort = 0;
        #1;
        vectors++;
        if (bus.sb_activation !== old || m_tile !== old) begin errors++; $display("FAIL abort_idle_sb got=%h want=%h", bus.sb_activation, old); end
        vectors++;
        if (obs !== 5'b10000) begin errors++; $display("FAIL abort_idle_ctl got=%b want=%b", obs, 5'b10000); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.abort = ($urandom_range(0, 23) == 0);
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_activation = rand_tile();
            #1;
            vectors++;
            if (obs !== exp_ctl()) begin errors++; $display("FAIL rand_ctl_c%0d got=%b want=%b", c, obs, exp_ctl()); end
            vectors++;
            if (bus.sb_activation !== m_tile) begin errors++; $display("FAIL rand_sb_c%0d got=%h want=%h", c, bus.sb_activation, m_tile); end
`ifdef SEQ_PERF_CNT_EN
            vectors++;
            if (perf_tiles !== m_tiles || perf_busy !== m_cycles)
                begin errors++; $display("FAIL rand_perf_c%0d got=%0d/%0d want=%0d/%0d", c, perf_tiles, perf_busy, m_tiles, m_cycles); end
`endif
            tick();
        end
        bus.abort = 0;
    endtask

`ifdef SEQ_PERF_CNT_EN
    task automatic test_perf();
        logic [31:0] t0, b0;
        drain();
        t0 = perf_tiles; b0 = perf_busy;
        bus.out_ready = 1; bus.in_valid = 1;
        for (int c = 0; c < 42; c++) begin
            bus.in_activation = rand_tile();
            tick();
        end
        bus.in_valid = 0;
        #1;
        vectors++;
        if (perf_tiles - t0 !== 32'd3) begin errors++; $display("FAIL perf_tiles got=%0d want=3", perf_tiles - t0); end
        vectors++;
        if (perf_busy - b0 !== 32'd39) begin errors++; $display("FAIL perf_busy got=%0d want=39", perf_busy - b0); end
        bus.out_ready = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_abort();
        test_abort_idle();
        test_random();
`ifdef SEQ_PERF_CNT_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
